// File: rtl/icache_refill_engine.sv
// Instruction-cache line refill: one AXI4 INCR read burst per miss, beats
// assembled into a full line; at most one burst outstanding.
module icache_refill_engine #(
   parameter int unsigned ID_WIDTH   = 13,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned LINE_BYTES = 64,
   parameter int unsigned AXI_ID     = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic                    flush,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [ADDR_WIDTH-1:0]   resp_addr,
   output logic [LINE_BYTES*8-1:0] resp_line,
   output logic                    resp_error,
   output logic [ID_WIDTH-1:0]     m_axi_arid,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic                    m_axi_arlock,
   output logic [3:0]              m_axi_arcache,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [ID_WIDTH-1:0]     m_axi_rid,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   localparam int unsigned BEATS = LINE_BYTES / (DATA_WIDTH / 8);
   localparam int unsigned CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ID_WIDTH-1:0]   ARID      = ID_WIDTH'(AXI_ID) & ~ID_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

   typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

   state_t                    state;
   logic [CNT_W-1:0]          beat_cnt;
   logic                      err;
   logic                      drop;
   logic [ADDR_WIDTH-1:0]     line_addr;
   logic [LINE_BYTES*8-1:0]   line;

   // R beats always return here; the ID carries no information for this block.
   logic unused_rid;
   assign unused_rid = ^m_axi_rid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         err       <= 1'b0;
         drop      <= 1'b0;
         line_addr <= '0;
         line      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  line_addr <= req_addr & LINE_MASK;
                  beat_cnt  <= '0;
                  err       <= 1'b0;
                  drop      <= 1'b0;
                  state     <= AR;
               end
            end
            AR: begin
               if (flush) drop <= 1'b1;
               if (m_axi_arready) state <= R;
            end
            R: begin
               if (flush) drop <= 1'b1;
               if (m_axi_rvalid) begin
                  line[beat_cnt*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
                  beat_cnt <= beat_cnt + 1'b1;
                  if (m_axi_rresp != 2'b00) err <= 1'b1;
                  // burst ends on the final slot or on an early rlast; either mismatch is an error
                  if (beat_cnt == LAST_BEAT || m_axi_rlast) begin
                     if ((beat_cnt == LAST_BEAT) != m_axi_rlast) err <= 1'b1;
                     state <= (drop || flush) ? IDLE : RESP;
                  end
               end
            end
            RESP: begin
               if (resp_ready || drop || flush) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready     = (state == IDLE);
   assign m_axi_arvalid = (state == AR);
   assign m_axi_rready  = (state == R);
   assign resp_valid    = (state == RESP) && !drop;
   assign resp_addr     = line_addr;
   assign resp_line     = line;
   assign resp_error    = err;

   assign m_axi_arid    = ARID;
   assign m_axi_araddr  = line_addr;
   assign m_axi_arlen   = 8'(BEATS - 1);
   assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0000;
   assign m_axi_arprot  = 3'b100;

endmodule

// File: tb/tb_icache_refill_engine.sv
// Directed bench for icache_refill_engine: stimulus pushes expected AR and
// line responses into queues, negedge monitors pop and compare on handshakes.
module tb_icache_refill_engine;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [63:0]   req_addr;
   logic          flush;
   logic          resp_valid;
   logic          resp_ready;
   logic [63:0]   resp_addr;
   logic [511:0]  resp_line;
   logic          resp_error;
   logic [12:0]   m_axi_arid;
   logic [63:0]   m_axi_araddr;
   logic [7:0]    m_axi_arlen;
   logic [2:0]    m_axi_arsize;
   logic [1:0]    m_axi_arburst;
   logic          m_axi_arlock;
   logic [3:0]    m_axi_arcache;
   logic [2:0]    m_axi_arprot;
   logic          m_axi_arvalid;
   logic          m_axi_arready;
   logic [12:0]   m_axi_rid;
   logic [63:0]   m_axi_rdata;
   logic [1:0]    m_axi_rresp;
   logic          m_axi_rlast;
   logic          m_axi_rvalid;
   logic          m_axi_rready;

   icache_refill_engine #(
      .ID_WIDTH   (13),
      .ADDR_WIDTH (64),
      .DATA_WIDTH (64),
      .LINE_BYTES (64),
      .AXI_ID     (0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .flush         (flush),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_addr     (resp_addr),
      .resp_line     (resp_line),
      .resp_error    (resp_error),
      .m_axi_arid    (m_axi_arid),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arlock  (m_axi_arlock),
      .m_axi_arcache (m_axi_arcache),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rid     (m_axi_rid),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready)
   );

   typedef struct {
      logic [63:0]  addr;
      logic [511:0] line;
      logic         err;
   } resp_t;

   resp_t        resp_q[$];
   logic [63:0]  ar_q[$];
   int           n_vec = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           fno = 0;
   logic [511:0] model_line = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] beat_val(input int f, input int k);
      logic [7:0] tag;
      tag = 8'(f);
      return (64'h1111_1111_1111_1111 * 64'(k)) ^ {tag, 56'h0};
   endfunction

   // monitors
   logic [97:0]  ar_now, ar_snap;
   logic [576:0] rs_now, rs_snap;
   bit           ar_hold = 0, rs_hold = 0;
   logic [63:0]  ar_exp;
   resp_t        rs_exp;

   assign ar_now = {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                    m_axi_arlock, m_axi_arcache, m_axi_arprot};
   assign rs_now = {resp_addr, resp_line, resp_error};

   always @(negedge clk) begin
      if (reset) begin
         ar_hold = 0;
         rs_hold = 0;
      end else begin
         if (m_axi_arvalid) begin
            if (ar_hold) chk("ar_stable", 512'(ar_now), 512'(ar_snap));
            if (m_axi_arready) begin
               ar_hold = 0;
               if (ar_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL ar_unexpected: got addr %0h required no AR", m_axi_araddr);
               end else begin
                  ar_exp = ar_q.pop_front();
                  chk("ar_addr",  512'(m_axi_araddr), 512'(ar_exp));
                  chk("ar_len",   512'(m_axi_arlen), 512'(7));
                  chk("ar_size",  512'(m_axi_arsize), 512'(3));
                  chk("ar_burst", 512'(m_axi_arburst), 512'(1));
                  chk("ar_id",    512'(m_axi_arid), 512'(0));
                  chk("ar_lock",  512'(m_axi_arlock), 512'(0));
                  chk("ar_cache", 512'(m_axi_arcache), 512'(0));
                  chk("ar_prot",  512'(m_axi_arprot), 512'(4));
               end
            end else begin
               ar_hold = 1;
               ar_snap = ar_now;
            end
         end else begin
            ar_hold = 0;
         end

         if (resp_valid) begin
            if (rs_hold) chk("resp_stable", 512'(rs_now ^ rs_snap), 512'(0));
            if (resp_ready) begin
               rs_hold = 0;
               if (resp_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL resp_unexpected: got addr %0h required no response", resp_addr);
               end else begin
                  rs_exp = resp_q.pop_front();
                  chk("resp_addr",  512'(resp_addr), 512'(rs_exp.addr));
                  chk("resp_line",  resp_line, rs_exp.line);
                  chk("resp_error", 512'(resp_error), 512'(rs_exp.err));
               end
            end else begin
               rs_hold = 1;
               rs_snap = rs_now;
            end
         end else begin
            rs_hold = 0;
         end
      end
   end

   // One line fill. Negative beat indices disable the corresponding feature.
   task automatic fill(input logic [63:0] addr, input int ar_dly, input int gap,
                       input int err_beat, input int last_beat, input int flush_beat,
                       input int resp_dly, input bit flush_resp, input int rst_beat,
                       input logic [63:0] next_addr, input bit chk_lat);
      logic [63:0]  la;
      logic [511:0] exp_line;
      bit           dropped;
      int           acc;
      int           f;
      resp_t        r;
      f = fno;
      fno++;
      la = addr & ~64'h3F;
      dropped = (flush_beat >= 0) || flush_resp || (rst_beat >= 0);
      exp_line = model_line;
      for (int k = 0; k <= last_beat; k++) exp_line[k*64 +: 64] = beat_val(f, k);
      ar_q.push_back(la);
      if (!dropped) begin
         r.addr = la;
         r.line = exp_line;
         r.err  = (err_beat >= 0 && err_beat <= last_beat) || (last_beat != 7);
         resp_q.push_back(r);
      end
      resp_ready = (resp_dly == 0) && !flush_resp;
      req_valid  = 1'b1;
      req_addr   = addr;
      acc        = cyc;
      chk("req_ready_idle", 512'(req_ready), 512'(1));
      tick();
      if (next_addr != 64'h0) req_addr = next_addr;
      else req_valid = 1'b0;
      chk("arvalid_rise", 512'(m_axi_arvalid), 512'(1));
      chk("req_ready_busy", 512'(req_ready), 512'(0));
      for (int i = 0; i < ar_dly; i++) begin
         tick();
         chk("ar_held", 512'(m_axi_arvalid), 512'(1));
      end
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0;
      chk("rready_rise", 512'(m_axi_rready), 512'(1));
      chk("arvalid_fall", 512'(m_axi_arvalid), 512'(0));
      for (int k = 0; k <= last_beat; k++) begin
         for (int g = 0; g < gap; g++) tick();
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = beat_val(f, k);
         m_axi_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
         m_axi_rlast  = (k == last_beat);
         flush        = (k == flush_beat);
         tick();
         m_axi_rvalid = 1'b0;
         m_axi_rlast  = 1'b0;
         m_axi_rresp  = 2'b00;
         flush        = 1'b0;
         if (k == rst_beat) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("rst_req_ready", 512'(req_ready), 512'(1));
            chk("rst_rready", 512'(m_axi_rready), 512'(0));
            chk("rst_resp_valid", 512'(resp_valid), 512'(0));
            model_line = '0;
            resp_ready = 1'b1;
            return;
         end
      end
      if (flush_beat >= 0) begin
         chk("flush_no_resp", 512'(resp_valid), 512'(0));
         chk("flush_idle", 512'(req_ready), 512'(1));
         resp_ready = 1'b1;
         return;
      end
      model_line = exp_line;
      chk("resp_rise", 512'(resp_valid), 512'(1));
      if (chk_lat) chk("resp_latency", 512'(cyc - acc), 512'(10));
      if (flush_resp) begin
         tick();
         flush = 1'b1;
         tick();
         flush = 1'b0;
         chk("flush_resp_drop", 512'(resp_valid), 512'(0));
         chk("flush_resp_idle", 512'(req_ready), 512'(1));
         resp_ready = 1'b1;
         return;
      end
      for (int i = 0; i < resp_dly; i++) begin
         tick();
         chk("resp_held", 512'(resp_valid), 512'(1));
         chk("resp_held_busy", 512'(req_ready), 512'(0));
      end
      resp_ready = 1'b1;
      tick();
      chk("ready_after_hs", 512'(req_ready), 512'(1));
      chk("resp_fall", 512'(resp_valid), 512'(0));
   endtask

   initial begin
      reset         = 1'b1;
      req_valid     = 1'b0;
      req_addr      = '0;
      flush         = 1'b0;
      resp_ready    = 1'b1;
      m_axi_arready = 1'b0;
      m_axi_rid     = '0;
      m_axi_rdata   = '0;
      m_axi_rresp   = 2'b00;
      m_axi_rlast   = 1'b0;
      m_axi_rvalid  = 1'b0;
      repeat (3) tick();
      chk("rst_req_ready", 512'(req_ready), 512'(1));
      chk("rst_arvalid", 512'(m_axi_arvalid), 512'(0));
      chk("rst_rready", 512'(m_axi_rready), 512'(0));
      chk("rst_resp_valid", 512'(resp_valid), 512'(0));
      chk("rst_resp_error", 512'(resp_error), 512'(0));
      chk("rst_resp_line", resp_line, 512'(0));
      chk("rst_resp_addr", 512'(resp_addr), 512'(0));
      reset = 1'b0;
      tick();

      //   addr          ard gap err last flb rdly frs rst next       lat
      fill(64'h1_0038,   0,  0,  -1, 7,   -1, 0,   0,  -1, 64'h0,    1);
      fill(64'h4_0010,   5,  2,  -1, 7,   -1, 3,   0,  -1, 64'h0,    0);
      fill(64'h5_00C0,   1,  0,  3,  7,   -1, 0,   0,  -1, 64'h0,    0);
      fill(64'h6_1234,   0,  1,  -1, 5,   -1, 1,   0,  -1, 64'h0,    0);
      fill(64'h7_0000,   0,  1,  -1, 7,   2,  0,   0,  -1, 64'h0,    0);
      fill(64'h8_0008,   0,  0,  -1, 7,   -1, 0,   1,  -1, 64'h0,    0);
      fill(64'h2000,     2,  0,  -1, 7,   -1, 0,   0,  -1, 64'h3040, 0);
      fill(64'h3040,     0,  1,  -1, 7,   -1, 2,   0,  -1, 64'h0,    0);
      fill(64'h9_0040,   0,  0,  -1, 7,   -1, 0,   0,  4,  64'h0,    0);
      fill(64'hA_007F,   0,  0,  -1, 7,   -1, 0,   0,  -1, 64'h0,    1);

      repeat (3) tick();
      chk("ar_q_drained", 512'(ar_q.size()), 512'(0));
      chk("resp_q_drained", 512'(resp_q.size()), 512'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of run by %0t required completion", $time);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
      $fatal(1);
   end

endmodule
